// File: rtl/priority_request_scheduler_if.sv
// ---------------------------------------------------------------------------
// priority_request_scheduler_if
//
// Purpose: groups the request, encoder, and grant signals of the
// priority_request_scheduler into one bundle.
//
// Signals (directions as seen from the scheduler, modport "slave"):
//   req_set  in   WIDTH  one-cycle request pulses, bit i sets pending bit i
//   pnd      out  WIDTH  registered pending vector, feeds encoder dec_vld
//   enc_idx  in   IW     encoder index result
//   enc_vld  in   1      encoder valid result
//   gnt_vld  out  1      grant valid
//   gnt_idx  out  IW     granted index, stable while gnt_vld=1
//   gnt_rdy  in   1      consumer accepts the grant
//   busy     out  1      scheduler FSM is not IDLE
//
// Grant handshake: a transfer happens on a rising clk edge where
// gnt_vld=1 and gnt_rdy=1. Once gnt_vld rises it stays high, with gnt_idx
// unchanged, until that transfer (or reset). gnt_rdy may be driven
// independently of gnt_vld.
//
// Modport "master" is the environment side (request source, encoder,
// grant consumer).
// ---------------------------------------------------------------------------
interface priority_request_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int IW    = $clog2(WIDTH)
);
    logic [WIDTH-1:0] req_set;
    logic [WIDTH-1:0] pnd;
    logic [IW-1:0]    enc_idx;
    logic             enc_vld;
    logic             gnt_vld;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_rdy;
    logic             busy;

    modport slave (
        input  req_set,
        input  enc_idx,
        input  enc_vld,
        input  gnt_rdy,
        output pnd,
        output gnt_vld,
        output gnt_idx,
        output busy
    );

    modport master (
        output req_set,
        output enc_idx,
        output enc_vld,
        output gnt_rdy,
        input  pnd,
        input  gnt_vld,
        input  gnt_idx,
        input  busy
    );
endinterface

// File: rtl/priority_request_scheduler.sv
// ---------------------------------------------------------------------------
// priority_request_scheduler
//
// Purpose: upstream stage of the registered priority encoder wrapper.
// Request pulses are accumulated into a pending vector that is driven onto
// the encoder input. After a fixed wait for the encoder result, one grant
// is issued on a valid/ready handshake and the granted pending bit is
// cleared, so every request is serviced exactly once.
//
// Parameters:
//   WIDTH    number of request lines (must match the encoder)
//   LATENCY  cycles from pnd to a valid encoder result, 0..15
//            (0 = combinational encoder)
//   IW       index width, derived from WIDTH
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   bus          slave modport of priority_request_scheduler_if
//   dbg_state_o  out  current FSM state (0=IDLE, 1=WAIT, 2=GRANT)
//
// Grant handshake: transfer on a rising clk edge with gnt_vld=1 and
// gnt_rdy=1. gnt_vld only falls on that transfer or on reset; gnt_idx is
// held constant while gnt_vld=1.
//
// All outputs come straight from registers; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module priority_request_scheduler #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int IW      = $clog2(WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    priority_request_scheduler_if.slave       bus,
    output logic [1:0]                        dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    // Wait counter load value. The IDLE->WAIT edge already accounts for one
    // cycle of encoder latency, so WAIT runs LATENCY-1 extra cycles.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pnd_q, pnd_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [IW-1:0]    gnt_idx_q, gnt_idx_d;

    logic             handshake;
    logic [WIDTH-1:0] clr;
    logic             sample_enc;

    // -----------------------------------------------------------------------
    // Pending vector
    // -----------------------------------------------------------------------
    assign handshake = gnt_vld_q & bus.gnt_rdy;

    // One-hot clear of the granted bit, only on the transfer cycle.
    assign clr = handshake ? (WIDTH'(1) << gnt_idx_q) : '0;

    // The set term is ORed in last so a new pulse on the bit being cleared
    // survives: that request is granted again in a later transaction.
    assign pnd_d = (pnd_q & ~clr) | bus.req_set;

    // -----------------------------------------------------------------------
    // FSM next-state and grant register logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_idx_d  = gnt_idx_q;
        sample_enc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pnd_q != '0) begin
                    if (LATENCY == 0) begin
                        // Combinational encoder: its result already reflects
                        // pnd_q, so act as the end of WAIT right away.
                        sample_enc = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sample_enc = 1'b1;
                end
            end

            ST_GRANT: begin
                if (bus.gnt_rdy) begin
                    gnt_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = 4'd0;
                gnt_vld_d = 1'b0;
            end
        endcase

        // End of the encoder wait. The sampled index reflects pnd as it was
        // when the wait began; bits set since then are left for the next
        // transaction. The winning bit is still pending because clears
        // only happen in GRANT.
        if (sample_enc) begin
            if (bus.enc_vld) begin
                state_d   = ST_GRANT;
                gnt_vld_d = 1'b1;
                gnt_idx_d = bus.enc_idx;
            end else begin
                // Nothing to grant (pending drained); go back to IDLE.
                state_d   = ST_IDLE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pnd_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pnd_q     <= pnd_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all register-driven)
    // -----------------------------------------------------------------------
    assign bus.pnd     = pnd_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_priority_request_scheduler.sv
module tb_priority_request_scheduler;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 2;
    localparam int IW      = 3;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_vec;
    int n_err;

    priority_request_scheduler_if #(.WIDTH(WIDTH), .IW(IW)) sif ();

    priority_request_scheduler #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY),
        .IW     (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (sif),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------- encoder model: lowest index wins, two register stages -----
    function automatic logic [IW:0] lowest(input logic [WIDTH-1:0] v);
        logic [IW:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [IW:0] enc_s1, enc_s2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_s1 <= '0;
            enc_s2 <= '0;
        end else begin
            enc_s1 <= lowest(sif.pnd);
            enc_s2 <= enc_s1;
        end
    end
    assign sif.enc_vld = enc_s2[IW];
    assign sif.enc_idx = enc_s2[IW-1:0];

    // ---------------- driver tasks ----------------
    // Advance to 2 time units after the next rising edge: inputs driven here
    // are captured at the following edge, and outputs read here are the
    // values for the current cycle.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst         = 1'b0;
        sif.req_set = '0;
        sif.gnt_rdy = 1'b1;
        run_cycles(2);
        n_vec++;
        if (sif.pnd !== 8'h00) begin n_err++; $display("FAIL reset_pnd: got %h want 00", sif.pnd); end
        n_vec++;
        if (sif.gnt_vld !== 1'b0) begin n_err++; $display("FAIL reset_gnt_vld: got %b want 0", sif.gnt_vld); end
        n_vec++;
        if (sif.gnt_idx !== 3'd0) begin n_err++; $display("FAIL reset_gnt_idx: got %0d want 0", sif.gnt_idx); end
        n_vec++;
        if (sif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", sif.busy); end
        n_vec++;
        if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst = 1'b1;
        run_cycles(2);
    endtask

    task automatic test_single_pulse();
        next_cycle();                      // cycle 0
        sif.req_set = 8'h10;
        next_cycle();                      // cycle 1
        sif.req_set = 8'h00;
        n_vec++;
        if (sif.pnd !== 8'h10) begin n_err++; $display("FAIL single_pnd_c1: got %h want 10", sif.pnd); end
        next_cycle();                      // cycle 2
        n_vec++;
        if (sif.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_c2: got %b want 1", sif.busy); end
        next_cycle();                      // cycle 3
        n_vec++;
        if (sif.gnt_vld !== 1'b0) begin n_err++; $display("FAIL single_early_gnt_c3: got %b want 0", sif.gnt_vld); end
        next_cycle();                      // cycle 4
        n_vec++;
        if (sif.gnt_vld !== 1'b1) begin n_err++; $display("FAIL single_gnt_vld_c4: got %b want 1", sif.gnt_vld); end
        n_vec++;
        if (sif.gnt_idx !== 3'd4) begin n_err++; $display("FAIL single_gnt_idx_c4: got %0d want 4", sif.gnt_idx); end
        next_cycle();                      // cycle 5
        n_vec++;
        if (sif.pnd !== 8'h00) begin n_err++; $display("FAIL single_pnd_c5: got %h want 00", sif.pnd); end
        n_vec++;
        if (sif.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_c5: got %b want 0", sif.busy); end
        n_vec++;
        if (sif.gnt_vld !== 1'b0) begin n_err++; $display("FAIL single_gnt_drop_c5: got %b want 0", sif.gnt_vld); end
        run_cycles(2);
    endtask

    task automatic test_multiple_pending();
        logic [IW-1:0] exp_q[$];
        logic [IW-1:0] exp_idx;
        exp_q = '{3'd0, 3'd2, 3'd7};
        next_cycle();                      // cycle 0
        sif.req_set = 8'h85;
        next_cycle();                      // cycle 1
        sif.req_set = 8'h00;
        for (int k = 0; k < 3; k++) begin
            run_cycles(2);                 // cycle 3 + 4k
            n_vec++;
            if (sif.gnt_vld !== 1'b0) begin n_err++; $display("FAIL multi_gap_%0d: got %b want 0", k, sif.gnt_vld); end
            next_cycle();                  // cycle 4 + 4k
            exp_idx = exp_q.pop_front();
            n_vec++;
            if (sif.gnt_vld !== 1'b1) begin n_err++; $display("FAIL multi_gnt_vld_%0d: got %b want 1", k, sif.gnt_vld); end
            n_vec++;
            if (sif.gnt_idx !== exp_idx) begin n_err++; $display("FAIL multi_gnt_idx_%0d: got %0d want %0d", k, sif.gnt_idx, exp_idx); end
            next_cycle();                  // cycle 5 + 4k
        end
        n_vec++;
        if (sif.pnd !== 8'h00) begin n_err++; $display("FAIL multi_pnd_end: got %h want 00", sif.pnd); end
        n_vec++;
        if (sif.busy !== 1'b0) begin n_err++; $display("FAIL multi_busy_end: got %b want 0", sif.busy); end
        run_cycles(2);
    endtask

    task automatic test_backpressure();
        sif.gnt_rdy = 1'b0;
        next_cycle();                      // cycle 0
        sif.req_set = 8'h02;
        next_cycle();                      // cycle 1
        sif.req_set = 8'h00;
        run_cycles(3);                     // cycle 4
        for (int k = 0; k < 10; k++) begin // cycles 4..13
            n_vec++;
            if (sif.gnt_vld !== 1'b1) begin n_err++; $display("FAIL bp_gnt_vld_%0d: got %b want 1", k, sif.gnt_vld); end
            n_vec++;
            if (sif.gnt_idx !== 3'd1) begin n_err++; $display("FAIL bp_gnt_idx_%0d: got %0d want 1", k, sif.gnt_idx); end
            n_vec++;
            if (sif.pnd !== 8'h02) begin n_err++; $display("FAIL bp_pnd_%0d: got %h want 02", k, sif.pnd); end
            next_cycle();
        end
        sif.gnt_rdy = 1'b1;                // cycle 14: handshake at its end
        next_cycle();                      // cycle 15
        n_vec++;
        if (sif.pnd !== 8'h00) begin n_err++; $display("FAIL bp_pnd_after: got %h want 00", sif.pnd); end
        n_vec++;
        if (sif.gnt_vld !== 1'b0) begin n_err++; $display("FAIL bp_gnt_vld_after: got %b want 0", sif.gnt_vld); end
        run_cycles(2);
    endtask

    task automatic test_set_clear_collision();
        next_cycle();                      // cycle 0
        sif.req_set = 8'h08;
        next_cycle();                      // cycle 1
        sif.req_set = 8'h00;
        run_cycles(3);                     // cycle 4: handshake cycle
        n_vec++;
        if (sif.gnt_idx !== 3'd3) begin n_err++; $display("FAIL coll_first_idx: got %0d want 3", sif.gnt_idx); end
        sif.req_set = 8'h08;
        next_cycle();                      // cycle 5
        sif.req_set = 8'h00;
        n_vec++;
        if (sif.pnd !== 8'h08) begin n_err++; $display("FAIL coll_pnd_kept: got %h want 08", sif.pnd); end
        n_vec++;
        if (sif.gnt_vld !== 1'b0) begin n_err++; $display("FAIL coll_gnt_drop: got %b want 0", sif.gnt_vld); end
        run_cycles(3);                     // cycle 8
        n_vec++;
        if (sif.gnt_vld !== 1'b1) begin n_err++; $display("FAIL coll_second_vld: got %b want 1", sif.gnt_vld); end
        n_vec++;
        if (sif.gnt_idx !== 3'd3) begin n_err++; $display("FAIL coll_second_idx: got %0d want 3", sif.gnt_idx); end
        next_cycle();                      // cycle 9
        n_vec++;
        if (sif.pnd !== 8'h00) begin n_err++; $display("FAIL coll_pnd_end: got %h want 00", sif.pnd); end
        run_cycles(2);
    endtask

    task automatic test_late_high_priority();
        next_cycle();                      // cycle 0
        sif.req_set = 8'h40;
        next_cycle();                      // cycle 1
        sif.req_set = 8'h00;
        next_cycle();                      // cycle 2: WAIT
        n_vec++;
        if (dbg_state !== 2'd1) begin n_err++; $display("FAIL late_state_wait: got %0d want 1", dbg_state); end
        sif.req_set = 8'h01;
        next_cycle();                      // cycle 3
        sif.req_set = 8'h00;
        n_vec++;
        if (sif.pnd !== 8'h41) begin n_err++; $display("FAIL late_pnd: got %h want 41", sif.pnd); end
        next_cycle();                      // cycle 4
        n_vec++;
        if (sif.gnt_idx !== 3'd6 || sif.gnt_vld !== 1'b1) begin
            n_err++; $display("FAIL late_first: got vld=%b idx=%0d want vld=1 idx=6", sif.gnt_vld, sif.gnt_idx);
        end
        next_cycle();                      // cycle 5
        n_vec++;
        if (sif.pnd !== 8'h01) begin n_err++; $display("FAIL late_pnd_mid: got %h want 01", sif.pnd); end
        run_cycles(3);                     // cycle 8
        n_vec++;
        if (sif.gnt_idx !== 3'd0 || sif.gnt_vld !== 1'b1) begin
            n_err++; $display("FAIL late_second: got vld=%b idx=%0d want vld=1 idx=0", sif.gnt_vld, sif.gnt_idx);
        end
        next_cycle();                      // cycle 9
        n_vec++;
        if (sif.pnd !== 8'h00) begin n_err++; $display("FAIL late_pnd_end: got %h want 00", sif.pnd); end
        run_cycles(2);
    endtask

    task automatic test_async_reset();
        sif.gnt_rdy = 1'b0;
        next_cycle();                      // cycle 0
        sif.req_set = 8'h20;
        next_cycle();                      // cycle 1
        sif.req_set = 8'h00;
        run_cycles(3);                     // cycle 4: GRANT, held off
        n_vec++;
        if (sif.gnt_vld !== 1'b1) begin n_err++; $display("FAIL arst_pre_gnt: got %b want 1", sif.gnt_vld); end
        #1;
        rst = 1'b0;                        // mid-cycle, away from any edge
        #1;
        n_vec++;
        if (sif.gnt_vld !== 1'b0) begin n_err++; $display("FAIL arst_gnt_vld: got %b want 0", sif.gnt_vld); end
        n_vec++;
        if (sif.pnd !== 8'h00) begin n_err++; $display("FAIL arst_pnd: got %h want 00", sif.pnd); end
        n_vec++;
        if (sif.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", sif.busy); end
        sif.gnt_rdy = 1'b1;
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            n_vec++;
            if (sif.gnt_vld !== 1'b0 || sif.pnd !== 8'h00) begin
                n_err++; $display("FAIL arst_quiet_%0d: got vld=%b pnd=%h want vld=0 pnd=00", k, sif.gnt_vld, sif.pnd);
            end
        end
        sif.req_set = 8'h01;               // cycle 0
        next_cycle();                      // cycle 1
        sif.req_set = 8'h00;
        run_cycles(3);                     // cycle 4
        n_vec++;
        if (sif.gnt_vld !== 1'b1 || sif.gnt_idx !== 3'd0) begin
            n_err++; $display("FAIL arst_new_grant: got vld=%b idx=%0d want vld=1 idx=0", sif.gnt_vld, sif.gnt_idx);
        end
        run_cycles(2);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_pulse();
        test_multiple_pending();
        test_backpressure();
        test_set_clear_collision();
        test_late_high_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
